layer_stream_driver: RTL

LAYER_STREAM_DRIVER -- requirements
Module: layer_stream_driver

---
 rtl/layer_stream_driver_pkg.sv | 16 +
 rtl/layer_stream_driver_stream_buf.sv | 39 +++
 rtl/layer_stream_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/layer_stream_driver_pkg.sv
// Shared types and default sizes for the layer stream driver.
// Imported by the driver top and its bench.
package layer_stream_driver_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_RECV = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam int unsigned T_DEF = 16;
   localparam int unsigned N_DEF = 10;
   localparam int unsigned M_DEF = 8;

endpackage

// File: rtl/layer_stream_driver_stream_buf.sv
// Small buffer: one write port, one registered read port.
// Out-of-range writes are dropped; out-of-range reads return zero.
module stream_buf #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 10,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i && (int'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (int'(raddr_i) < DEPTH) begin
         rdata_q <= mem_q[raddr_i];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_stream_driver.sv
// Streams a host-loaded vector into a layer and captures its results,
// with an idle timeout on the result side.
module layer_stream_driver
   import layer_stream_driver_pkg::*;
#(
   parameter int T       = T_DEF,
   parameter int N       = N_DEF,
   parameter int M       = M_DEF,
   parameter int TIMEOUT = 1023,
   parameter int XAW     = (N > 1) ? $clog2(N) : 1,
   parameter int YAW     = (M > 1) ? $clog2(M) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                x_wr_en,
   input  logic [XAW-1:0]      x_wr_addr,
   input  logic signed [T-1:0] x_wr_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic signed [T-1:0] data_out,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic signed [T-1:0] data_in,
   input  logic [YAW-1:0]      y_rd_addr,
   output logic signed [T-1:0] y_rd_data,
   output logic                busy,
   output logic                done,
   output logic                timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [XAW-1:0] X_LAST = XAW'(N - 1);
   localparam logic [YAW-1:0] Y_LAST = YAW'(M - 1);
   localparam logic [CW-1:0]  TO_V   = CW'(TIMEOUT);

   state_e         state_q, state_d;
   logic [XAW-1:0] idx_q, idx_d;
   logic [YAW-1:0] ridx_q, ridx_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
   logic           terr_q, terr_d;
   logic           x_xfer, y_acc;
   logic [T-1:0]   x_rdata, y_rdata;

   assign x_xfer  = m_valid && m_ready;
   assign y_acc   = s_valid && s_ready;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ridx_d  = ridx_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SEND;
               idx_d   = '0;
               ridx_d  = '0;
               cnt_d   = '0;
               terr_d  = 1'b0;
            end
         end
         S_SEND: begin
            if (x_xfer) begin
               if (idx_q == X_LAST) begin
                  idx_d   = '0;
                  state_d = S_RECV;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_RECV: begin
            if (y_acc) begin
               cnt_d = '0;
               if (ridx_q == Y_LAST) begin
                  ridx_d  = '0;
                  state_d = S_DONE;
               end else begin
                  ridx_d = ridx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TO_V) begin
                  terr_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ridx_q  <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ridx_q  <= ridx_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   // Read at idx_d so xbuf[idx] is already on data_out in the first SEND cycle.
   stream_buf #(
      .WIDTH (T),
      .DEPTH (N),
      .AW    (XAW)
   ) u_xbuf (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (x_wr_en && (state_q == S_IDLE)),
      .waddr_i (x_wr_addr),
      .wdata_i (x_wr_data),
      .raddr_i (idx_d),
      .rdata_o (x_rdata)
   );

   stream_buf #(
      .WIDTH (T),
      .DEPTH (M),
      .AW    (YAW)
   ) u_ybuf (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (y_acc),
      .waddr_i (ridx_q),
      .wdata_i (data_in),
      .raddr_i (y_rd_addr),
      .rdata_o (y_rdata)
   );

   assign data_out    = x_rdata;
   assign y_rd_data   = y_rdata;
   assign m_valid     = (state_q == S_SEND);
   assign s_ready     = (state_q == S_RECV);
   assign done        = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign timeout_err = terr_q;

endmodule
